// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified single-port memory between fetch (I) and load/store (D) with bounded I starvation.
// Define MEM_ARB_MISALIGN_TRAP_EN to block misaligned half/word accesses and report them on d_err.
module mem_port_arbiter #(
  parameter int STARVE_MAX = 3,
  parameter int CNT_W      = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [1:0]  d_size,
  input  logic        d_unsigned,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        m_we,
  output logic [31:0] m_a,
  output logic [31:0] m_wd,
  output logic [3:0]  m_wm,
  input  logic [31:0] m_rd
);

  typedef enum logic [1:0] {IDLE, RESP_I, RESP_D} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] starve_cnt_reg, starve_cnt_next;
  logic             force_i;
  logic             misalign;
  logic [1:0]       lo;

  logic [31:0] word_reg;
  logic [1:0]  lo_reg, size_reg;
  logic        uns_reg, we_reg, err_reg;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  assign lo      = d_addr[1:0];
  assign force_i = (starve_cnt_reg == CNT_W'(STARVE_MAX));
  assign d_gnt   = d_req && !force_i;
  assign i_gnt   = i_req && (!d_req || force_i);

`ifdef MEM_ARB_MISALIGN_TRAP_EN
  assign misalign = ((d_size == 2'b01) && lo[0]) || (d_size[1] && (lo != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // Reset gates the write so a store granted as reset asserts never lands.
  assign m_a  = d_gnt ? d_addr : i_addr;
  assign m_we = reset_n && d_gnt && d_we && !misalign;

  always_comb begin
    m_wm = 4'b1111;
    m_wd = d_wdata;
    case (d_size)
      2'b00: begin
        m_wm = 4'b0001 << lo;
        m_wd = {4{d_wdata[7:0]}};
      end
      2'b01: begin
        m_wm = 4'b0011 << {lo[1], 1'b0};
        m_wd = {2{d_wdata[15:0]}};
      end
      default: begin
        m_wm = 4'b1111;
        m_wd = d_wdata;
      end
    endcase
  end

  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (!i_req || i_gnt)
      starve_cnt_next = '0;
    else if (!force_i)
      starve_cnt_next = starve_cnt_reg + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      starve_cnt_reg <= '0;
    end else begin
      state_reg      <= state_next;
      starve_cnt_reg <= starve_cnt_next;
    end
  end

  // Lane/extension info rides along with the captured word; only RESP_D uses it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_reg <= '0;
      lo_reg   <= '0;
      size_reg <= '0;
      uns_reg  <= 1'b0;
      we_reg   <= 1'b0;
      err_reg  <= 1'b0;
    end else if (i_gnt || d_gnt) begin
      word_reg <= m_rd;
      lo_reg   <= lo;
      size_reg <= d_size;
      uns_reg  <= d_unsigned;
      we_reg   <= d_we;
      err_reg  <= d_gnt && misalign;
    end
  end

  always_comb begin
    byte_sel = word_reg[7:0];
    case (lo_reg)
      2'd0:    byte_sel = word_reg[7:0];
      2'd1:    byte_sel = word_reg[15:8];
      2'd2:    byte_sel = word_reg[23:16];
      default: byte_sel = word_reg[31:24];
    endcase
    half_sel = lo_reg[1] ? word_reg[31:16] : word_reg[15:0];
    case (size_reg)
      2'b00:   load_ext = {{24{!uns_reg && byte_sel[7]}}, byte_sel};
      2'b01:   load_ext = {{16{!uns_reg && half_sel[15]}}, half_sel};
      default: load_ext = word_reg;
    endcase
  end

  always_comb begin
    state_next = IDLE;
    if (i_gnt)
      state_next = RESP_I;
    else if (d_gnt)
      state_next = RESP_D;

    i_rvalid = 1'b0;
    i_rdata  = '0;
    d_rvalid = 1'b0;
    d_rdata  = '0;
    d_err    = 1'b0;
    case (state_reg)
      RESP_I: begin
        i_rvalid = 1'b1;
        i_rdata  = word_reg;
      end
      RESP_D: begin
        d_rvalid = 1'b1;
        d_err    = err_reg;
        if (!we_reg && !err_reg)
          d_rdata = load_ext;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: behavioural memory, per-scenario tasks with inline checks.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt, i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req, d_we, d_unsigned;
  logic [31:0] d_addr, d_wdata;
  logic [1:0]  d_size;
  logic        d_gnt, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic        m_we;
  logic [31:0] m_a, m_wd, m_rd;
  logic [3:0]  m_wm;

  logic [31:0] mem [0:63];
  bit          mem_loaded;
  int          errors = 0;
  int          checks = 0;
  logic [32:0] d_q [$];
  logic [31:0] i_q [$];

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_MAX(3), .CNT_W(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_size(d_size), .d_unsigned(d_unsigned),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .m_we(m_we), .m_a(m_a), .m_wd(m_wd), .m_wm(m_wm), .m_rd(m_rd)
  );

  assign m_rd = mem[m_a[7:2]];

  // Contents are loaded on the first reset edge, then only byte-masked writes touch them.
  always @(posedge clk) begin
    if (!reset_n && !mem_loaded) begin
      for (int k = 0; k < 64; k++) mem[k] <= 32'h0;
      mem[4]     <= 32'h8899AABB;
      mem[8]     <= 32'h11223344;
      mem[12]    <= 32'h55667788;
      mem_loaded <= 1'b1;
    end else if (m_we) begin
      for (int b = 0; b < 4; b++)
        if (m_wm[b]) mem[m_a[7:2]][8*b +: 8] <= m_wd[8*b +: 8];
    end
  end

  task automatic d_op(input string name, input logic we, input logic [31:0] addr,
                      input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                      input logic [3:0] exp_wm, input logic [31:0] exp_wd, input logic exp_mwe,
                      input logic [31:0] exp_rdata, input logic exp_err);
    int n;
    logic [32:0] exp;
    d_req = 1'b1; d_we = we; d_addr = addr; d_size = size; d_unsigned = uns; d_wdata = wdata;
    d_q.push_back({exp_err, exp_rdata});
    n = 0;
    @(negedge clk);
    while (d_gnt !== 1'b1 && n < 16) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (d_gnt !== 1'b1) begin
      errors++;
      $display("FAIL %s d_gnt: got %b want 1", name, d_gnt);
    end
    checks++;
    if (m_we !== exp_mwe) begin
      errors++;
      $display("FAIL %s m_we: got %b want %b", name, m_we, exp_mwe);
    end
    if (exp_mwe) begin
      checks++;
      if (m_wm !== exp_wm || m_wd !== exp_wd || m_a !== addr) begin
        errors++;
        $display("FAIL %s lanes: got wm=%b wd=%h a=%h want wm=%b wd=%h a=%h",
                 name, m_wm, m_wd, m_a, exp_wm, exp_wd, addr);
      end
    end
    @(posedge clk);
    #1;
    d_req = 1'b0;
    exp = d_q.pop_front();
    checks++;
    if (d_rvalid !== 1'b1 || d_err !== exp[32] || d_rdata !== exp[31:0]) begin
      errors++;
      $display("FAIL %s resp: got rvalid=%b err=%b rdata=%h want rvalid=1 err=%b rdata=%h",
               name, d_rvalid, d_err, d_rdata, exp[32], exp[31:0]);
    end
    $display("d_op %-8s we=%b addr=%h size=%b rdata=%h err=%b", name, we, addr, size, d_rdata, d_err);
  endtask

  task automatic i_op(input string name, input logic [31:0] addr, input logic [31:0] exp_rdata);
    int n;
    logic [31:0] exp;
    i_req = 1'b1; i_addr = addr;
    i_q.push_back(exp_rdata);
    n = 0;
    @(negedge clk);
    while (i_gnt !== 1'b1 && n < 16) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (i_gnt !== 1'b1 || m_we !== 1'b0) begin
      errors++;
      $display("FAIL %s i_gnt: got gnt=%b m_we=%b want gnt=1 m_we=0", name, i_gnt, m_we);
    end
    @(posedge clk);
    #1;
    i_req = 1'b0;
    exp = i_q.pop_front();
    checks++;
    if (i_rvalid !== 1'b1 || i_rdata !== exp) begin
      errors++;
      $display("FAIL %s resp: got rvalid=%b rdata=%h want rvalid=1 rdata=%h", name, i_rvalid, i_rdata, exp);
    end
    $display("i_op %-8s addr=%h rdata=%h", name, addr, i_rdata);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_size = 2'b00; d_unsigned = 1'b0; d_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({i_rvalid, d_rvalid, d_err, m_we, i_gnt, d_gnt} !== 6'b0) begin
      errors++;
      $display("FAIL reset flags: got %b want 000000", {i_rvalid, d_rvalid, d_err, m_we, i_gnt, d_gnt});
    end
    checks++;
    if (i_rdata !== 32'h0 || d_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset data: got i_rdata=%h d_rdata=%h want 0", i_rdata, d_rdata);
    end
    reset_n = 1'b1;
    $display("reset released");
  endtask

  task automatic test_load_ext();
    d_op("lb_13", 1'b0, 32'h13, 2'b00, 1'b0, '0, 4'h0, '0, 1'b0, 32'hFFFFFF88, 1'b0);
    d_op("lbu_13", 1'b0, 32'h13, 2'b00, 1'b1, '0, 4'h0, '0, 1'b0, 32'h00000088, 1'b0);
    d_op("lb_10", 1'b0, 32'h10, 2'b00, 1'b0, '0, 4'h0, '0, 1'b0, 32'hFFFFFFBB, 1'b0);
    d_op("lhu_10", 1'b0, 32'h10, 2'b01, 1'b1, '0, 4'h0, '0, 1'b0, 32'h0000AABB, 1'b0);
    d_op("lh_12", 1'b0, 32'h12, 2'b01, 1'b0, '0, 4'h0, '0, 1'b0, 32'hFFFF8899, 1'b0);
    d_op("lw11_10", 1'b0, 32'h10, 2'b11, 1'b0, '0, 4'h0, '0, 1'b0, 32'h8899AABB, 1'b0);
  endtask

  task automatic test_store_lanes();
    d_op("sb_21", 1'b1, 32'h21, 2'b00, 1'b0, 32'h000000C3, 4'b0010, 32'hC3C3C3C3, 1'b1, 32'h0, 1'b0);
    d_op("lw_20", 1'b0, 32'h20, 2'b10, 1'b0, '0, 4'h0, '0, 1'b0, 32'h1122C344, 1'b0);
    d_op("sh_22", 1'b1, 32'h22, 2'b01, 1'b0, 32'h0000BEEF, 4'b1100, 32'hBEEFBEEF, 1'b1, 32'h0, 1'b0);
    d_op("lh_22", 1'b0, 32'h22, 2'b01, 1'b0, '0, 4'h0, '0, 1'b0, 32'hFFFFBEEF, 1'b0);
    d_op("lhu_22", 1'b0, 32'h22, 2'b01, 1'b1, '0, 4'h0, '0, 1'b0, 32'h0000BEEF, 1'b0);
    i_op("if_20", 32'h20, 32'hBEEFC344);
  endtask

  task automatic test_back_to_back();
    bit exp_i [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [32:0] dexp;
    logic [31:0] iexp;
    i_req = 1'b1; i_addr = 32'h20;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10; d_size = 2'b10; d_unsigned = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (i_gnt !== exp_i[k] || d_gnt !== !exp_i[k]) begin
        errors++;
        $display("FAIL arb cycle %0d: got i_gnt=%b d_gnt=%b want i_gnt=%b d_gnt=%b",
                 k, i_gnt, d_gnt, exp_i[k], !exp_i[k]);
      end
      if (exp_i[k]) i_q.push_back(32'hBEEFC344);
      else          d_q.push_back({1'b0, 32'h8899AABB});
      @(posedge clk);
      #1;
      if (k == 7) begin
        i_req = 1'b0;
        d_req = 1'b0;
      end
      checks++;
      if (exp_i[k]) begin
        iexp = i_q.pop_front();
        if (i_rvalid !== 1'b1 || d_rvalid !== 1'b0 || i_rdata !== iexp) begin
          errors++;
          $display("FAIL arb resp %0d: got i_rvalid=%b d_rvalid=%b i_rdata=%h want 1 0 %h",
                   k, i_rvalid, d_rvalid, i_rdata, iexp);
        end
      end else begin
        dexp = d_q.pop_front();
        if (d_rvalid !== 1'b1 || i_rvalid !== 1'b0 || d_rdata !== dexp[31:0]) begin
          errors++;
          $display("FAIL arb resp %0d: got d_rvalid=%b i_rvalid=%b d_rdata=%h want 1 0 %h",
                   k, d_rvalid, i_rvalid, d_rdata, dexp[31:0]);
        end
      end
      $display("arb cycle %0d grant=%s", k, exp_i[k] ? "I" : "D");
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] iexp;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10; d_size = 2'b10; d_unsigned = 1'b0;
    @(negedge clk);
    checks++;
    if (d_gnt !== 1'b1) begin
      errors++;
      $display("FAIL rstmid grant: got d_gnt=%b want 1", d_gnt);
    end
    @(posedge clk);
    reset_n = 1'b0;
    d_req = 1'b0;
    #1;
    checks++;
    if ({i_rvalid, d_rvalid, d_err} !== 3'b000 || i_rdata !== 32'h0 || d_rdata !== 32'h0) begin
      errors++;
      $display("FAIL rstmid outputs: got rv=%b%b err=%b i_rdata=%h d_rdata=%h want all 0",
               i_rvalid, d_rvalid, d_err, i_rdata, d_rdata);
    end
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h30; d_size = 2'b10; d_wdata = 32'hDEADBEEF;
    @(negedge clk);
    checks++;
    if (m_we !== 1'b0) begin
      errors++;
      $display("FAIL rstmid m_we: got %b want 0", m_we);
    end
    @(posedge clk);
    #1;
    checks++;
    if (d_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid d_rvalid: got %b want 0", d_rvalid);
    end
    d_req = 1'b0; d_we = 1'b0;
    reset_n = 1'b1;
    i_req = 1'b1; i_addr = 32'h10;
    @(negedge clk);
    checks++;
    if (i_gnt !== 1'b1) begin
      errors++;
      $display("FAIL rstmid first i_gnt: got %b want 1", i_gnt);
    end
    i_q.push_back(32'h8899AABB);
    @(posedge clk);
    #1;
    i_req = 1'b0;
    iexp = i_q.pop_front();
    checks++;
    if (i_rvalid !== 1'b1 || i_rdata !== iexp) begin
      errors++;
      $display("FAIL rstmid fetch: got rvalid=%b rdata=%h want 1 %h", i_rvalid, i_rdata, iexp);
    end
    $display("reset mid-transfer done");
    d_op("lw_30", 1'b0, 32'h30, 2'b10, 1'b0, '0, 4'h0, '0, 1'b0, 32'h55667788, 1'b0);
  endtask

  task automatic test_misalign();
`ifdef MEM_ARB_MISALIGN_TRAP_EN
    d_op("lh_11", 1'b0, 32'h11, 2'b01, 1'b0, '0, 4'h0, '0, 1'b0, 32'h0, 1'b1);
    d_op("sw_31", 1'b1, 32'h31, 2'b10, 1'b0, 32'hCAFEF00D, 4'hF, 32'hCAFEF00D, 1'b0, 32'h0, 1'b1);
    d_op("lw_30b", 1'b0, 32'h30, 2'b10, 1'b0, '0, 4'h0, '0, 1'b0, 32'h55667788, 1'b0);
`else
    d_op("lh_11", 1'b0, 32'h11, 2'b01, 1'b0, '0, 4'h0, '0, 1'b0, 32'hFFFFAABB, 1'b0);
    d_op("sw_31", 1'b1, 32'h31, 2'b10, 1'b0, 32'hCAFEF00D, 4'hF, 32'hCAFEF00D, 1'b1, 32'h0, 1'b0);
    d_op("lw_30b", 1'b0, 32'h30, 2'b10, 1'b0, '0, 4'h0, '0, 1'b0, 32'hCAFEF00D, 1'b0);
`endif
  endtask

  initial begin
    test_reset();
    test_load_ext();
    test_store_lanes();
    test_back_to_back();
    test_reset_mid();
    test_misalign();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port unified instruction/data memory between the fetch requester (I) and the load/store requester (D).
- Arbitrates between the two requesters with data priority and bounded starvation of I.
- Generates the byte-lane write mask and replicated write data for sb/sh/sw.
- Registers read responses, including sign/zero extension for lb/lbu/lh/lhu.
- Sits between the core's fetch/LSU stages and the memory (clk, we, a, wd, wm in; rd out).

Parameters:
- STARVE_MAX, 3: consecutive cycles a pending I request may lose to D before I is forced to win.
- CNT_W, 2: width of the starvation counter; must satisfy STARVE_MAX < 2**CNT_W.

Ports:
- clk  in  1  clock; all state updates on posedge
- reset_n  in  1  asynchronous, active-low reset
- i_req  in  1  fetch request; held with i_addr stable until granted
- i_addr  in  32  fetch byte address; bits [1:0] are ignored
- i_gnt  out  1  fetch accepted this cycle
- i_rvalid  out  1  fetch data valid; pulses one cycle after i_gnt
- i_rdata  out  32  fetched word
- d_req  in  1  data request; held with all d_* inputs stable until granted
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  data byte address
- d_size  in  2  00 = byte, 01 = half, 10 = word; 11 is treated as word
- d_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- d_wdata  in  32  store data, right-aligned
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  data response valid; pulses one cycle after d_gnt, for loads and stores
- d_rdata  out  32  extended load data; 0 for stores
- d_err  out  1  misaligned access; meaningful only with the optional feature, otherwise tied 0
- m_we  out  1  memory write enable
- m_a  out  32  memory address
- m_wd  out  32  memory write data
- m_wm  out  4  memory byte-lane mask; bit n enables byte n
- m_rd  in  32  memory read data; combinational from m_a

Behaviour:
- Memory access is single cycle: the grant cycle drives m_a and m_we. The memory reads combinationally and writes on the following posedge.
- Grant logic is combinational:
  - d_gnt = d_req && !force_i.
  - i_gnt = i_req && (!d_req || force_i).
  - force_i = (starve_cnt == STARVE_MAX).
  - At most one grant per cycle.
- starve_cnt:
  - Increments when i_req && !i_gnt, saturating at STARVE_MAX.
  - Clears to 0 on i_gnt or when i_req is low.
- Memory drive:
  - On d_gnt: m_a = d_addr, m_we = d_we.
  - Otherwise: m_a = i_addr, m_we = 0.
  - m_wm and m_wd are don't-care whenever m_we = 0.
- Store lanes, with lo = d_addr[1:0]:
  - Byte: m_wm = 4'b0001 << lo; m_wd = {4{d_wdata[7:0]}}.
  - Half: m_wm = 4'b0011 << {lo[1],1'b0}; m_wd = {2{d_wdata[15:0]}}.
  - Word: m_wm = 4'b1111; m_wd = d_wdata.
- Response FSM states: IDLE, RESP_I, RESP_D. The next state follows this cycle's grant (i_gnt -> RESP_I, d_gnt -> RESP_D, neither -> IDLE).
  - New grants are allowed in any state, so back-to-back requests give one access per cycle.
- Response registers:
  - On a grant, capture m_rd plus d_addr[1:0], d_size, d_unsigned and d_we.
  - In RESP_I: i_rvalid = 1, i_rdata = captured word.
  - In RESP_D: d_rvalid = 1.
    - Load byte: the byte at lane lo, extended to 32 bits.
    - Load half: the halfword at lane lo[1], extended to 32 bits.
    - Load word: the full captured word.
    - Store: d_rdata = 0.
- Reset (async, mid-transfer included): state = IDLE, starve_cnt = 0, i_rvalid = d_rvalid = 0, i_rdata = d_rdata = 0, d_err = 0.
  - A response pending at reset is dropped.
  - A store granted in the same cycle reset asserts must not be written; m_we is gated by reset_n.

Optional Feature:
- Macro: MEM_ARB_MISALIGN_TRAP_EN.
- With the macro defined:
  - A half access with d_addr[0] = 1, or a word access with d_addr[1:0] != 0, is still granted.
  - The access is blocked: m_we = 0.
  - Next cycle: d_rvalid = 1, d_err = 1, d_rdata = 0.
  - Memory contents are unchanged.
- Without the macro:
  - Misaligned accesses are forced to the aligned lanes (half uses lo[1]; word ignores lo).
  - d_err is constant 0.

Test Plan:
- Memory word 0x10 = 0x8899AABB; load byte signed at 0x13 -> d_rvalid next cycle, d_rdata = 0xFFFFFF88. Load byte unsigned at 0x13 -> 0x00000088.
- sb of 0x000000C3 at 0x21, with word 0x20 = 0x11223344 -> m_wm = 0010, m_wd = 0xC3C3C3C3; a later lw 0x20 returns 0x1122C344.
- sh of 0xBEEF at 0x22 -> m_wm = 1100; a later lh 0x22 returns 0xFFFFBEEF and lhu 0x22 returns 0x0000BEEF.
- i_req and d_req held high for 8 cycles (STARVE_MAX = 3) -> grant sequence D,D,D,I,D,D,D,I. Each i_rvalid/d_rvalid follows its grant by exactly one cycle.
- reset_n pulled low in the cycle after a load grant -> d_rvalid stays 0 and all outputs return to their reset values. After release, i_req is granted in the first cycle.
- With MEM_ARB_MISALIGN_TRAP_EN, sw at 0x31 -> m_we = 0, next cycle d_err = 1, d_rvalid = 1; word 0x30 is unchanged.
